// File: rtl/deser_pkg.sv
// Shared definitions for the serial-in/parallel-out receiver:
// FSM state encoding, default frame width and the counter-width helper.
package deser_pkg;

  localparam int unsigned DESER_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_PAR  = 3'd2,
    ST_STOP = 3'd3,
    ST_BRK  = 3'd4
  } state_e;

  // Bits needed to hold a count of 0..w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Shadow shift register for the receiver. Each enabled shift moves the word
// one place toward index 1 and loads the serial input at index WIDTH, so after
// WIDTH shifts the first received bit sits at index 1.
module sipo_shreg
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH = DESER_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           shift_en_i,
  input  logic           sin_i,
  output logic [1:WIDTH] par_o
);

  logic [1:WIDTH] shadow_q;

  // Shift toward index 1 while enabled; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (shift_en_i) begin
      shadow_q <= {shadow_q[2:WIDTH], sin_i};
    end
  end

  assign par_o = shadow_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out receiver: start bit, WIDTH data bits (y[1] first),
// optional even-parity bit, stop bit. Presents the recovered word with a
// one-cycle valid strobe, or a framing/parity error strobe.
// Optional feature: define DESER_PARITY_EN to add the parity bit and par_err.
module sipo_deser
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH = DESER_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           din,
  output logic [1:WIDTH] y,
  output logic           valid,
  output logic           busy,
  output logic           frm_err,
  output logic           par_err
);

  localparam int unsigned   CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:WIDTH] y_q, y_d;
  logic           valid_q, valid_d;
  logic           frm_err_q, frm_err_d;
  logic           shift_en;
  logic [1:WIDTH] shadow;
`ifdef DESER_PARITY_EN
  logic           par_bad_q, par_bad_d;
  logic           par_err_q, par_err_d;
`endif

  sipo_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en_i (shift_en),
    .sin_i      (din),
    .par_o      (shadow)
  );

  // Next-state, counter, output word and strobe decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    valid_d   = 1'b0;
    frm_err_d = 1'b0;
    shift_en  = 1'b0;
`ifdef DESER_PARITY_EN
    par_bad_d = par_bad_q;
    par_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!din) begin
          state_d = ST_DATA;
          cnt_d   = '0;
`ifdef DESER_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      ST_DATA: begin
        shift_en = 1'b1;
        if (cnt_q == LAST) begin
`ifdef DESER_PARITY_EN
          state_d = ST_PAR;
`else
          state_d = ST_STOP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PAR: begin
`ifdef DESER_PARITY_EN
        // Shadow is complete here; even parity means data ^ parity bit == 0.
        par_bad_d = (^shadow) ^ din;
        state_d   = ST_STOP;
`else
        state_d   = ST_IDLE;
`endif
      end
      ST_STOP: begin
        if (din) begin
          state_d = ST_IDLE;
`ifdef DESER_PARITY_EN
          if (par_bad_q) begin
            par_err_d = 1'b1;
          end else begin
            y_d     = shadow;
            valid_d = 1'b1;
          end
`else
          y_d     = shadow;
          valid_d = 1'b1;
`endif
        end else begin
          // Parity outcome is dropped on a framing error.
          frm_err_d = 1'b1;
          state_d   = ST_BRK;
        end
      end
      ST_BRK: begin
        if (din) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, output word and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      frm_err_q <= frm_err_d;
    end
  end

`ifdef DESER_PARITY_EN
  // Parity mismatch record and its error strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign y       = y_q;
  assign valid   = valid_q;
  assign frm_err = frm_err_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sipo_deser.sv
module tb_sipo_deser;

  localparam int W = 4;
`ifdef DESER_PARITY_EN
  localparam int FRAME = W + 3;
`else
  localparam int FRAME = W + 2;
`endif

  localparam logic [2:0] K_VALID = 3'b001;
  localparam logic [2:0] K_FRM   = 3'b010;
  localparam logic [2:0] K_PAR   = 3'b100;

  typedef struct {
    logic [2:0] kind;
    logic [1:W] word;
    int         gap;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic [1:W] y;
  logic       valid;
  logic       busy;
  logic       frm_err;
  logic       par_err;

  int checks   = 0;
  int failures = 0;
  exp_t exp_q[$];
  logic [1:W] model_y = '0;
  int cyc = 0;
  int last_valid_cyc = 0;

  sipo_deser #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .y       (y),
    .valid   (valid),
    .busy    (busy),
    .frm_err (frm_err),
    .par_err (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pops an expectation on every strobe and tracks the word y must hold.
  always @(negedge clk) begin
    exp_t e;
    logic [2:0] got_k;
    cyc++;
    if (!rst_n) begin
      model_y = '0;
    end else begin
      got_k = {par_err, frm_err, valid};
      if (got_k != 3'b000) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe got={par,frm,valid}=%b exp=none t=%0t", got_k, $time);
        end else begin
          e = exp_q.pop_front();
          if (got_k !== e.kind) begin
            failures++;
            $display("FAIL strobe_kind got=%b exp=%b t=%0t", got_k, e.kind, $time);
          end
          if (e.kind == K_VALID) model_y = e.word;
          if (e.gap != 0) begin
            checks++;
            if (cyc - last_valid_cyc != e.gap) begin
              failures++;
              $display("FAIL valid_gap got=%0d exp=%0d", cyc - last_valid_cyc, e.gap);
            end
          end
        end
        if (valid) last_valid_cyc = cyc;
      end
      checks++;
      if (y !== model_y) begin
        failures++;
        $display("FAIL y_word got=%b exp=%b t=%0t", y, model_y, $time);
      end
    end
  end

  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [1:W] w, input logic stop_b,
                            input logic flip, input int gap);
    exp_t e;
    send_bit(1'b0);
    chk("busy_after_start", busy, 1);
    for (int i = 1; i <= W; i++) send_bit(w[i]);
`ifdef DESER_PARITY_EN
    send_bit((^w) ^ flip);
`endif
    e.word = w;
    e.gap  = 0;
    if (!stop_b)   e.kind = K_FRM;
    else if (flip) e.kind = K_PAR;
    else begin
      e.kind = K_VALID;
      e.gap  = gap;
    end
    exp_q.push_back(e);
    send_bit(stop_b);
    chk("busy_after_stop", busy, {31'b0, ~stop_b});
  endtask

  initial begin
    rst_n = 1'b0;
    din   = 1'b1;
    // Reset held with the line toggling.
    for (int i = 0; i < 4; i++) begin
      din = i[0];
      @(posedge clk);
      #1;
      chk("rst_y", y, 0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frm", frm_err, 0);
      chk("rst_par", par_err, 0);
    end
    din   = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);

    // Good frame, then back-to-back frames.
    send_frame(4'b1011, 1'b1, 1'b0, 0);
    chk("busy_idle_after_good", busy, 0);
    send_frame(4'b1011, 1'b1, 1'b0, 0);
    send_frame(4'b0110, 1'b1, 1'b0, FRAME);

    // Framing error: y holds 0110, busy stays up until the line returns high.
    send_frame(4'b1111, 1'b0, 1'b0, 0);
    send_bit(1'b0);
    chk("brk_busy_low_line", busy, 1);
    send_bit(1'b1);
    chk("brk_exit_busy", busy, 0);
    chk("frm_y_held", y, 4'b0110);

`ifdef DESER_PARITY_EN
    send_frame(4'b1011, 1'b1, 1'b0, 0);
    send_frame(4'b0110, 1'b1, 1'b1, 0);
    chk("par_y_held", y, 4'b1011);
    send_bit(1'b1);
`endif

    // Reset mid-frame after two data bits.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_y", y, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    din = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(4'b1100, 1'b1, 1'b0, 0);
    send_bit(1'b1);
    chk("final_y", y, 4'b1100);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
